hazard_stall_ctrl: RTL and testbench

Pipeline control end of the decode/execute register interface. It generates the write enables, flush and bubble controls consumed by the F/D, D/X, X/M and M/W pipeline flop banks. It detects load-use and branch-operand hazards by comparing ID source registers against D/X and X/M destinations. It freezes the pipe on memory stalls and drains the pipeline on HLT through a small state machine.

---
 rtl/hazard_stall_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard / stall / halt-drain controller for the F/D, D/X, X/M, M/W flop banks.
// Optional STALL_COUNTER_EN adds a saturating 16-bit stall_cycles counter output.
module hazard_stall_ctrl #(
  parameter int REG_W        = 4,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_Source1,
  input  logic [REG_W-1:0] id_Source2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_branch_reg,
  input  logic             id_branch_taken,
  input  logic             id_halt,
  input  logic             dx_MemRead,
  input  logic             dx_RegWrite,
  input  logic [REG_W-1:0] dx_reg_dest,
  input  logic             xm_MemRead,
  input  logic [REG_W-1:0] xm_reg_dest,
  input  logic             mem_stall,
  output logic             pc_wen,
  output logic             fd_wen,
  output logic             fd_flush,
  output logic             dx_wen,
  output logic             dx_bubble,
  output logic             xm_wen,
  output logic             mw_wen,
`ifdef STALL_COUNTER_EN
  output logic             halt_done,
  output logic [15:0]      stall_cycles
`else
  output logic             halt_done
`endif
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT_DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [3:0] drain_cnt;
  logic       dx_dest_nz;
  logic       xm_dest_nz;
  logic       load_use;
  logic       br_haz;
  logic       hazard;

  assign dx_dest_nz = (dx_reg_dest != '0);
  assign xm_dest_nz = (xm_reg_dest != '0);

  assign load_use = dx_MemRead & dx_RegWrite & dx_dest_nz &
                    ((id_use_src1 & (id_Source1 == dx_reg_dest)) |
                     (id_use_src2 & (id_Source2 == dx_reg_dest)));

  assign br_haz = id_branch_reg &
                  ((dx_RegWrite & dx_dest_nz & (id_Source1 == dx_reg_dest)) |
                   (xm_MemRead  & xm_dest_nz & (id_Source1 == xm_reg_dest)));

  assign hazard = load_use | br_haz;

  // MEM_WAIT shares RUN's output rules; it only records that the pipe was frozen.
  always_comb begin
    pc_wen    = 1'b0;
    fd_wen    = 1'b0;
    fd_flush  = 1'b0;
    dx_wen    = 1'b0;
    dx_bubble = 1'b0;
    xm_wen    = 1'b0;
    mw_wen    = 1'b0;
    halt_done = 1'b0;
    if (rst) begin
      dx_bubble = 1'b1;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            pc_wen = 1'b0;
          end else if (hazard) begin
            dx_wen    = 1'b1;
            xm_wen    = 1'b1;
            mw_wen    = 1'b1;
            dx_bubble = 1'b1;
          end else if (id_halt) begin
            fd_wen   = 1'b1;
            fd_flush = 1'b1;
            dx_wen   = 1'b1;
            xm_wen   = 1'b1;
            mw_wen   = 1'b1;
          end else begin
            pc_wen   = 1'b1;
            fd_wen   = 1'b1;
            fd_flush = id_branch_taken;
            dx_wen   = 1'b1;
            xm_wen   = 1'b1;
            mw_wen   = 1'b1;
          end
        end
        HALT_DRAIN: begin
          dx_bubble = 1'b1;
          dx_wen    = ~mem_stall;
          xm_wen    = ~mem_stall;
          mw_wen    = ~mem_stall;
        end
        HALTED: begin
          halt_done = 1'b1;
        end
        default: begin
          dx_bubble = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (mem_stall) begin
            state <= MEM_WAIT;
          end else if (hazard) begin
            state <= RUN;
          end else if (id_halt) begin
            drain_cnt <= DRAIN_LOAD;
            state     <= (DRAIN_CYCLES <= 1) ? HALTED : HALT_DRAIN;
          end else begin
            state <= RUN;
          end
        end
        HALT_DRAIN: begin
          // drain_cnt holds the non-stalled drain cycles still owed before HALTED
          if (!mem_stall) begin
            drain_cnt <= drain_cnt - 4'd1;
            if (drain_cnt <= 4'd1) state <= HALTED;
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (((state == RUN) || (state == MEM_WAIT)) && (mem_stall || hazard) &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: constant vector table, hand-written multi-cycle sequences,
// and randomized stimulus against a cycle-counting behavioural model.
module tb_hazard_stall_ctrl;
  localparam int REG_W = 4;
  localparam int DRAIN = 4;

  localparam logic [7:0] O_RUN  = 8'b11010110;
  localparam logic [7:0] O_STL  = 8'b00011110;
  localparam logic [7:0] O_FRZ  = 8'b00000000;
  localparam logic [7:0] O_RST  = 8'b00001000;
  localparam logic [7:0] O_DFRZ = 8'b00001000;
  localparam logic [7:0] O_HLT  = 8'b01110110;
  localparam logic [7:0] O_BT   = 8'b11110110;
  localparam logic [7:0] O_DONE = 8'b00000001;

  logic clk = 1'b0;
  logic rst;
  logic [REG_W-1:0] id_Source1, id_Source2, dx_reg_dest, xm_reg_dest;
  logic id_use_src1, id_use_src2, id_branch_reg, id_branch_taken, id_halt;
  logic dx_MemRead, dx_RegWrite, xm_MemRead, mem_stall;
  logic pc_wen, fd_wen, fd_flush, dx_wen, dx_bubble, xm_wen, mw_wen, halt_done;
`ifdef STALL_COUNTER_EN
  logic [15:0] stall_cycles;
  logic [15:0] sc0;
`endif

  typedef struct {
    logic [3:0] s1, s2;
    logic u1, u2, br, bt, hlt, dxmr, dxrw;
    logic [3:0] dxd;
    logic xmmr;
    logic [3:0] xmd;
    logic ms;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_drain, m_halt;
  int m_done;

  vec_t tbl[14];
  in_t  v;

  hazard_stall_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .id_Source1(id_Source1), .id_Source2(id_Source2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_branch_reg(id_branch_reg), .id_branch_taken(id_branch_taken), .id_halt(id_halt),
    .dx_MemRead(dx_MemRead), .dx_RegWrite(dx_RegWrite), .dx_reg_dest(dx_reg_dest),
    .xm_MemRead(xm_MemRead), .xm_reg_dest(xm_reg_dest), .mem_stall(mem_stall),
    .pc_wen(pc_wen), .fd_wen(fd_wen), .fd_flush(fd_flush), .dx_wen(dx_wen),
    .dx_bubble(dx_bubble), .xm_wen(xm_wen), .mw_wen(mw_wen),
`ifdef STALL_COUNTER_EN
    .halt_done(halt_done), .stall_cycles(stall_cycles)
`else
    .halt_done(halt_done)
`endif
  );

  always #5 clk = ~clk;

  function automatic in_t nop();
    in_t r;
    r.s1 = 0; r.s2 = 0; r.u1 = 0; r.u2 = 0; r.br = 0; r.bt = 0; r.hlt = 0;
    r.dxmr = 0; r.dxrw = 0; r.dxd = 0; r.xmmr = 0; r.xmd = 0; r.ms = 0;
    return r;
  endfunction

  function automatic in_t rnd();
    in_t r;
    r.s1 = 4'($urandom_range(0, 3)); r.s2 = 4'($urandom_range(0, 3));
    r.u1 = 1'($urandom_range(0, 1)); r.u2 = 1'($urandom_range(0, 1));
    r.br = 1'($urandom_range(0, 1)); r.bt = 1'($urandom_range(0, 1));
    r.hlt = ($urandom_range(0, 29) == 0);
    r.dxmr = 1'($urandom_range(0, 1)); r.dxrw = 1'($urandom_range(0, 1));
    r.dxd = 4'($urandom_range(0, 3));
    r.xmmr = 1'($urandom_range(0, 1)); r.xmd = 4'($urandom_range(0, 3));
    r.ms = ($urandom_range(0, 4) == 0);
    return r;
  endfunction

  task automatic apply(input in_t a);
    id_Source1 = a.s1; id_Source2 = a.s2; id_use_src1 = a.u1; id_use_src2 = a.u2;
    id_branch_reg = a.br; id_branch_taken = a.bt; id_halt = a.hlt;
    dx_MemRead = a.dxmr; dx_RegWrite = a.dxrw; dx_reg_dest = a.dxd;
    xm_MemRead = a.xmmr; xm_reg_dest = a.xmd; mem_stall = a.ms;
  endtask

  task automatic check(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    act = {pc_wen, fd_wen, fd_flush, dx_wen, dx_bubble, xm_wen, mw_wen, halt_done};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got {pc,fd,flush,dx,bub,xm,mw,done}=%b expected %b", nm, act, exp);
  endtask

  // one clock: drive at posedge+1, check at negedge, return at next posedge+1
  task automatic cyc(input in_t a, input string nm, input logic [7:0] exp);
    apply(a);
    #4;
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(nop());
    #4;
    check("reset_hold", O_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_drain = 0; m_halt = 0; m_done = 0;
  endtask

  // Reference: hazards straight from the rules; halt tracked as count of non-stalled cycles since HLT.
  function automatic bit model_hz(input in_t a);
    bit lu, bh;
    lu = a.dxmr && a.dxrw && (a.dxd != 0) &&
         ((a.u1 && a.s1 == a.dxd) || (a.u2 && a.s2 == a.dxd));
    bh = a.br && ((a.dxrw && a.dxd != 0 && a.s1 == a.dxd) ||
                  (a.xmmr && a.xmd != 0 && a.s1 == a.xmd));
    return lu || bh;
  endfunction

  function automatic logic [7:0] model_out(input in_t a);
    if (m_halt) return O_DONE;
    if (m_drain) return a.ms ? O_DFRZ : O_STL;
    if (a.ms) return O_FRZ;
    if (model_hz(a)) return O_STL;
    if (a.hlt) return O_HLT;
    if (a.bt) return O_BT;
    return O_RUN;
  endfunction

  task automatic model_step(input in_t a);
    if (m_halt) begin
      m_halt = 1;
    end else if (m_drain) begin
      if (!a.ms) begin
        m_done++;
        if (m_done >= DRAIN) begin m_halt = 1; m_drain = 0; end
      end
    end else if (!a.ms && !model_hz(a) && a.hlt) begin
      m_done = 1;
      if (m_done >= DRAIN) m_halt = 1;
      else m_drain = 1;
    end
  endtask

  initial begin
    for (int k = 0; k < 14; k++) tbl[k].i = nop();
    tbl[0].e = O_RUN;
    tbl[1].i.dxmr = 1; tbl[1].i.dxrw = 1; tbl[1].i.dxd = 3; tbl[1].i.s2 = 3; tbl[1].i.u2 = 1;
    tbl[1].e = O_STL;
    tbl[2].i.dxmr = 1; tbl[2].i.dxrw = 1; tbl[2].i.dxd = 0; tbl[2].i.s2 = 0; tbl[2].i.u2 = 1;
    tbl[2].e = O_RUN;
    tbl[3].i.dxmr = 1; tbl[3].i.dxrw = 1; tbl[3].i.dxd = 3; tbl[3].i.s1 = 3; tbl[3].i.u1 = 0;
    tbl[3].i.s2 = 4; tbl[3].i.u2 = 1; tbl[3].e = O_RUN;
    tbl[4].i.dxmr = 1; tbl[4].i.dxrw = 1; tbl[4].i.dxd = 3; tbl[4].i.s1 = 3; tbl[4].i.u1 = 1;
    tbl[4].e = O_STL;
    tbl[5].i.dxrw = 1; tbl[5].i.dxd = 3; tbl[5].i.s1 = 3; tbl[5].i.u1 = 1; tbl[5].e = O_RUN;
    tbl[6].i.br = 1; tbl[6].i.s1 = 5; tbl[6].i.dxrw = 1; tbl[6].i.dxd = 5; tbl[6].e = O_STL;
    tbl[7].i.br = 1; tbl[7].i.s1 = 5; tbl[7].i.xmmr = 1; tbl[7].i.xmd = 5; tbl[7].e = O_STL;
    tbl[8].i.br = 1; tbl[8].i.s1 = 5; tbl[8].i.xmd = 5; tbl[8].e = O_RUN;
    tbl[9].i.bt = 1; tbl[9].e = O_BT;
    tbl[10].i = tbl[6].i; tbl[10].i.bt = 1; tbl[10].e = O_STL;
    tbl[11].i = tbl[1].i; tbl[11].i.ms = 1; tbl[11].e = O_FRZ;
    tbl[12].i.br = 1; tbl[12].i.dxrw = 1; tbl[12].i.xmmr = 1; tbl[12].e = O_RUN;
    tbl[13].i.dxmr = 1; tbl[13].i.dxd = 3; tbl[13].i.s1 = 3; tbl[13].i.u1 = 1; tbl[13].e = O_RUN;

    rst = 1'b1;
    apply(nop());
    #2;
    check("reset_initial", O_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(nop(), "after_reset", O_RUN);

    for (int k = 0; k < 14; k++) cyc(tbl[k].i, $sformatf("table%0d", k), tbl[k].e);

    // load to r5 then BR on r5: D/X match, then X/M load match
    v = nop(); v.br = 1; v.s1 = 5; v.dxmr = 1; v.dxrw = 1; v.dxd = 5;
    cyc(v, "br_ld_dx", O_STL);
    v = nop(); v.br = 1; v.s1 = 5; v.xmmr = 1; v.xmd = 5;
    cyc(v, "br_ld_xm", O_STL);
    v = nop(); v.br = 1; v.s1 = 5;
    cyc(v, "br_go", O_RUN);

    // memory stall held over a load-use hazard
`ifdef STALL_COUNTER_EN
    sc0 = stall_cycles;
`endif
    v = nop(); v.dxmr = 1; v.dxrw = 1; v.dxd = 3; v.s2 = 3; v.u2 = 1; v.ms = 1;
    for (int k = 0; k < 3; k++) cyc(v, $sformatf("memstall%0d", k), O_FRZ);
    v.ms = 0;
    cyc(v, "memstall_bubble", O_STL);
`ifdef STALL_COUNTER_EN
    n_checks++;
    if (16'(stall_cycles - sc0) == 16'd4) n_pass++;
    else $display("FAIL stall_cycles_delta: got %0d expected 4", 16'(stall_cycles - sc0));
`endif
    cyc(nop(), "memstall_resume", O_RUN);

    // halt with simultaneous taken branch; hazards during drain are ignored
    v = nop(); v.hlt = 1; v.bt = 1;
    cyc(v, "halt_bt", O_HLT);
    v = tbl[6].i; v.bt = 1;
    for (int k = 0; k < DRAIN - 1; k++) cyc(v, $sformatf("drain%0d", k), O_STL);
    for (int k = 0; k < 3; k++) cyc(v, $sformatf("halted%0d", k), O_DONE);

    do_reset();
    v = nop(); v.hlt = 1;
    cyc(v, "halt2", O_HLT);
    cyc(nop(), "drain_a", O_STL);
    v = nop(); v.ms = 1;
    cyc(v, "drain_memstall", O_DFRZ);
    cyc(nop(), "drain_b", O_STL);
    cyc(nop(), "drain_c", O_STL);
    cyc(nop(), "halted_late", O_DONE);
    cyc(nop(), "halted_hold", O_DONE);

    // async reset asserted in the middle of a drain
    do_reset();
    v = nop(); v.hlt = 1;
    cyc(v, "halt3", O_HLT);
    cyc(nop(), "drain_pre_rst", O_STL);
    rst = 1'b1;
    #1;
    check("rst_mid_drain", O_RST);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(nop(), "run_after_rst", O_RUN);

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        v = rnd();
        apply(v);
        #4;
        check($sformatf("rand%0d", k), model_out(v));
        @(posedge clk);
        model_step(v);
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
